// File: rtl/pix_stream_fifo.sv
// Pixel-stream FIFO: stages framed pixel words, tags sof/sol/eol and
// presents them first-word-fall-through on a valid/ready output.
module pix_stream_fifo #(
    parameter int DATA_W    = 10,
    parameter int LANES     = 1,
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic                    sclk,
    input  logic                    rst_n,
    input  logic                    in_frame_valid,
    input  logic                    in_line_valid,
    input  logic [LANES*DATA_W-1:0] in_pixel_data,
    input  logic                    out_ready,
    input  logic                    clr_overflow,
    output logic                    out_frame_valid,
    output logic                    out_line_valid,
    output logic [LANES*DATA_W-1:0] out_pixel_data,
    output logic                    out_sol,
    output logic                    out_eol,
    output logic [ADDR_W:0]         fifo_level,
    output logic                    almost_full,
    output logic                    overflow
);

    localparam int PW    = LANES * DATA_W;
    localparam int EW    = PW + 3;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_LVL   = AFULL_LVL[ADDR_W:0];

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              fv_q, fv_d;
    logic              arm_q, arm_d;
    logic              line_open_q, line_open_d;
    logic              pend_vld_q, pend_vld_d;
    logic              pend_sof_q, pend_sof_d;
    logic              pend_sol_q, pend_sol_d;
    logic [PW-1:0]     pend_data_q, pend_data_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [EW-1:0]     mem_q [DEPTH];

    logic          qual;
    logic          empty;
    logic          full;
    logic [EW-1:0] head;
    logic          head_sof;
    logic          lv;
    logic          discard;
    logic          pop;
    logic          wr_ok;
    logic [EW-1:0] wr_entry;

    assign qual     = in_frame_valid & in_line_valid;
    assign empty    = (level_q == '0);
    assign full     = (level_q == FULL_LVL);
    assign head     = mem_q[rd_ptr_q];
    assign head_sof = head[EW-1];
    assign wr_entry = {pend_sof_q, pend_sol_q, ~qual, pend_data_q};

    always_comb begin
        lv = 1'b0;
        unique case (state_q)
            S_ACTIVE: lv = ~empty;
            S_DRAIN:  lv = ~empty & ~head_sof;
            default:  lv = 1'b0;
        endcase
    end

    // Headless words after a mid-frame start are flushed while idle
    assign discard = (state_q == S_IDLE) & ~empty & ~head_sof;
    assign pop     = (lv & out_ready) | discard;
    assign wr_ok   = pend_vld_q & (~full | pop);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (~empty & head_sof) state_d = S_ACTIVE;
            S_ACTIVE: if (~fv_q) state_d = S_DRAIN;
            S_DRAIN:  if (~pend_vld_q & (empty | head_sof)) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fv_d        = in_frame_valid;
        arm_d       = ~in_frame_valid | (arm_q & ~qual);
        line_open_d = in_line_valid & (line_open_q | qual);
        pend_vld_d  = qual;
        pend_sof_d  = pend_sof_q;
        pend_sol_d  = pend_sol_q;
        pend_data_d = pend_data_q;
        if (qual) begin
            pend_sof_d  = arm_q;
            pend_sol_d  = ~line_open_q;
            pend_data_d = in_pixel_data;
        end
        wr_ptr_d = wr_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({wr_ok, pop})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
        endcase
        ovf_d = ovf_q;
        if (pend_vld_q & full & ~pop) ovf_d = 1'b1;
        else if (clr_overflow)        ovf_d = 1'b0;
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fv_q        <= 1'b0;
            arm_q       <= 1'b0;
            line_open_q <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_sof_q  <= 1'b0;
            pend_sol_q  <= 1'b0;
            pend_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fv_q        <= fv_d;
            arm_q       <= arm_d;
            line_open_q <= line_open_d;
            pend_vld_q  <= pend_vld_d;
            pend_sof_q  <= pend_sof_d;
            pend_sol_q  <= pend_sol_d;
            pend_data_q <= pend_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign out_frame_valid = (state_q != S_IDLE);
    assign out_line_valid  = lv;
    assign out_pixel_data  = lv ? head[PW-1:0] : '0;
    assign out_sol         = lv & head[EW-2];
    assign out_eol         = lv & head[EW-3];
    assign fifo_level      = level_q;
    assign almost_full     = (level_q >= AF_LVL);
    assign overflow        = ovf_q;

endmodule
